// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN/ILEN      : address and instruction widths
//   RESET_PC_DEF   : default first fetch address after reset
//   fetch_state_e  : fetch sequencer states
//   fetch_entry_t  : one prefetched instruction with its PC
package ifetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_if.sv
// Bus bundle around the fetch unit.
//   mem_*      : single-outstanding request/ack port to instruction memory
//   insn_*     : valid/ready instruction stream toward decode
//   redirect*  : flush-and-restart request from execute
// master = fetch unit, slave = memory/decode/execute side.
interface ifetch_if;
  import ifetch_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [ILEN-1:0] mem_rdata;
  logic            insn_valid;
  logic [ILEN-1:0] insn;
  logic [XLEN-1:0] insn_pc;
  logic            insn_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, insn_valid, insn, insn_pc,
    input  mem_ack, mem_rdata, insn_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, insn_valid, insn, insn_pc,
    output mem_ack, mem_rdata, insn_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of DEPTH fetch entries.
//   clk, rst     : clock, async active-high reset
//   push_i/data  : write an entry (accepted when not full, or full with pop)
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : discard all entries; wins over push/pop
//   head_o       : head entry, read straight from storage flops
//   count_o, full_o, empty_o : occupancy
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [AW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Head comes from flops, so pushed data is visible one cycle after the ack.
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit.
//   clk, rst : clock, async active-high reset
//   bus      : ifetch_if.master (memory port, insn stream, redirect)
// Generates sequential PCs, keeps at most one memory request in flight and
// buffers returned words in a DEPTH-entry prefetch FIFO. A redirect flushes
// the FIFO; if a request is still in flight it is drained (data dropped)
// before fetching resumes at the redirect target.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;      // restart address held during DRAIN
  logic [XLEN-1:0] redir_tgt;
  logic            mem_req, ack, pop, push, flush;
  fetch_entry_t    push_data, head;
  logic [AW:0]     count;
  logic            full, empty;

  // rst gates the request directly so it drops the moment reset asserts.
  assign mem_req   = ~rst & ((state_q == REQ) | (state_q == DRAIN));
  assign ack       = bus.mem_ack & mem_req;
  assign pop       = ~empty & bus.insn_ready;
  assign redir_tgt = bus.redirect_pc & ~32'h3;

  assign push_data.pc   = fetch_pc_q;
  assign push_data.insn = bus.mem_rdata;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tgt_d      = tgt_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: if (!full || pop) state_d = REQ;
      REQ: begin
        if (ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          // Keep requesting only if the next word will have a slot.
          if (int'(count) + 1 - int'(pop) >= DEPTH) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (ack) begin
          state_d    = REQ;
          fetch_pc_d = tgt_q;
        end
      end
      default: state_d = REQ;
    endcase
    if (bus.redirect) begin
      flush = 1'b1;
      push  = 1'b0;
      if (mem_req && !ack) begin
        // Request still in flight: keep its address until the ack.
        state_d = DRAIN;
        tgt_d   = redir_tgt;
      end else begin
        state_d    = REQ;
        fetch_pc_d = redir_tgt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      tgt_q      <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tgt_q      <= tgt_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = fetch_pc_q;
  assign bus.insn_valid = ~empty;
  assign bus.insn       = head.insn;
  assign bus.insn_pc    = head.pc;
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus a randomized run checked
// against an in-order PC stream model (next expected PC, restarted by
// redirects) and memory-protocol invariants.
module tb_ifetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   lat = 0;      // memory wait cycles before ack
  int   wcnt = 0;     // cycles the current request has waited
  logic spur = 1'b0;  // ack pulse with no request, must be ignored

  ifetch_if bus();

  ifetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0013 ^ {29'b0, a[2], 2'b0} >> 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  assign bus.mem_ack   = spur | (bus.mem_req && (wcnt >= lat));
  assign bus.mem_rdata = memf(bus.mem_addr);

  task automatic apply_reset;
    rst = 1'b1;
    bus.insn_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    spur = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    bus.insn_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    #2 rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.insn_valid !== 1'b0 ||
          bus.insn !== 32'h0 || bus.insn_pc !== 32'h0) begin
        bad++;
        $display("FAIL reset_vals k=%0d got req=%b addr=%h v=%b insn=%h pc=%h want all 0",
                 k, bus.mem_req, bus.mem_addr, bus.insn_valid, bus.insn, bus.insn_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_seq;
    lat = 0;
    apply_reset;
    bus.insn_ready = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'(4 * i)) begin
        bad++;
        $display("FAIL seq_addr i=%0d got req=%b addr=%h want req=1 addr=%h",
                 i, bus.mem_req, bus.mem_addr, 32'(4 * i));
      end
      total++;
      if (i == 0) begin
        if (bus.insn_valid !== 1'b0) begin
          bad++;
          $display("FAIL seq_first_valid got %b want 0", bus.insn_valid);
        end
      end else if (bus.insn_valid !== 1'b1 || bus.insn_pc !== 32'(4 * (i - 1)) ||
                   bus.insn !== memf(32'(4 * (i - 1)))) begin
        bad++;
        $display("FAIL seq_insn i=%0d got v=%b pc=%h insn=%h want v=1 pc=%h insn=%h",
                 i, bus.insn_valid, bus.insn_pc, bus.insn, 32'(4 * (i - 1)), memf(32'(4 * (i - 1))));
      end
    end
  endtask

  task automatic test_stall;
    int acks = 0;
    logic [31:0] exp;
    lat = 0;
    apply_reset;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(negedge clk); spur = (i >= 6); #1; end
      if (bus.mem_req && bus.mem_ack) acks++;
    end
    @(negedge clk);
    spur = 1'b0;
    #1;
    total++;
    if (acks != 2 || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL stall_acks got acks=%0d req=%b want acks=2 req=0", acks, bus.mem_req);
    end
    total++;
    if (bus.insn_valid !== 1'b1 || bus.insn_pc !== 32'h0 || bus.insn !== memf(32'h0)) begin
      bad++;
      $display("FAIL stall_hold got v=%b pc=%h insn=%h want v=1 pc=0 insn=%h",
               bus.insn_valid, bus.insn_pc, bus.insn, memf(32'h0));
    end
    bus.insn_ready = 1'b1;
    exp = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      total++;
      if (bus.insn_valid !== 1'b1 || bus.insn_pc !== exp) begin
        bad++;
        $display("FAIL stall_resume i=%0d got v=%b pc=%h want v=1 pc=%h",
                 i, bus.insn_valid, bus.insn_pc, exp);
      end
      exp += 4;
    end
  endtask

  task automatic test_redirect_full;
    bit found = 0;
    lat = 0;
    apply_reset;
    repeat (4) @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    #1;
    total++;
    if (bus.mem_req !== 1'b0 || bus.insn_valid !== 1'b1) begin
      bad++;
      $display("FAIL rdf_pre got req=%b v=%b want req=0 v=1", bus.mem_req, bus.insn_valid);
    end
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    total++;
    if (bus.insn_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL rdf_flush got v=%b req=%b addr=%h want v=0 req=1 addr=00000100",
               bus.insn_valid, bus.mem_req, bus.mem_addr);
    end
    bus.insn_ready = 1'b1;
    for (int k = 0; k < 10 && !found; k++) begin
      if (bus.insn_valid) found = 1;
      else begin @(negedge clk); #1; end
    end
    total++;
    if (!found || bus.insn_pc !== 32'h100 || bus.insn !== memf(32'h100)) begin
      bad++;
      $display("FAIL rdf_first got found=%0d pc=%h want pc=00000100", found, bus.insn_pc);
    end
  endtask

  task automatic test_drain;
    bit found = 0;
    bit acked = 0;
    bit ok = 1;
    lat = 3;
    apply_reset;
    bus.insn_ready = 1'b1;
    #1;
    for (int k = 0; k < 300 && !found; k++) begin
      if (bus.mem_req && bus.mem_addr == 32'h40 && wcnt == 0) found = 1;
      else begin @(negedge clk); #1; end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL drain_reach got no request to 00000040 want one");
    end
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    @(negedge clk);
    bus.redirect = 1'b0;
    for (int k = 0; k < 10 && !acked && ok; k++) begin
      #1;
      if (!(bus.mem_req && bus.mem_addr == 32'h40) || bus.insn_valid) ok = 0;
      else if (bus.mem_ack) acked = 1;
      else @(negedge clk);
    end
    total++;
    if (!ok || !acked) begin
      bad++;
      $display("FAIL drain_hold got ok=%0d acked=%0d addr=%h v=%b want addr held 00000040 then ack",
               ok, acked, bus.mem_addr, bus.insn_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
      bad++;
      $display("FAIL drain_restart got req=%b addr=%h want req=1 addr=00000200",
               bus.mem_req, bus.mem_addr);
    end
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.insn_valid) found = 1;
      else begin @(negedge clk); #1; end
    end
    total++;
    if (!found || bus.insn_pc !== 32'h200) begin
      bad++;
      $display("FAIL drain_first got found=%0d pc=%h want pc=00000200", found, bus.insn_pc);
    end
  endtask

  task automatic test_double_redirect;
    bit found = 0;
    int n = 0;
    logic [31:0] exp = 32'h400;
    lat = 2;
    apply_reset;
    bus.insn_ready = 1'b1;
    #1;
    for (int k = 0; k < 50 && !found; k++) begin
      if (bus.mem_req && bus.mem_ack && bus.mem_addr == 32'h8) found = 1;
      else begin @(negedge clk); #1; end
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h300;
    @(negedge clk);
    bus.redirect_pc = 32'h380;
    #1;
    total++;
    if (!found || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300 || bus.mem_ack !== 1'b0) begin
      bad++;
      $display("FAIL dbl_req300 got found=%0d req=%b addr=%h ack=%b want req=1 addr=00000300 ack=0",
               found, bus.mem_req, bus.mem_addr, bus.mem_ack);
    end
    @(negedge clk);
    bus.redirect_pc = 32'h400;
    #1;
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300 || bus.insn_valid !== 1'b0) begin
      bad++;
      $display("FAIL dbl_drain got req=%b addr=%h v=%b want req=1 addr=00000300 v=0",
               bus.mem_req, bus.mem_addr, bus.insn_valid);
    end
    @(negedge clk);
    bus.redirect = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus.insn_valid && bus.insn_ready) begin
        total++;
        if (bus.insn_pc !== exp || bus.insn !== memf(exp)) begin
          bad++;
          $display("FAIL dbl_stream n=%0d got pc=%h insn=%h want pc=%h insn=%h",
                   n, bus.insn_pc, bus.insn, exp, memf(exp));
        end
        exp += 4;
        n++;
      end
      @(negedge clk);
    end
    total++;
    if (n < 5) begin
      bad++;
      $display("FAIL dbl_count got %0d deliveries want >=5", n);
    end
  endtask

  task automatic test_wrap_rst;
    logic [31:0] a;
    lat = 0;
    apply_reset;
    bus.insn_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    bus.redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      a = 32'hFFFF_FFF8 + 32'(4 * i);
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== a) begin
        bad++;
        $display("FAIL wrap_addr i=%0d got addr=%h want %h", i, bus.mem_addr, a);
      end
      if (i > 0) begin
        a = 32'hFFFF_FFF8 + 32'(4 * (i - 1));
        total++;
        if (bus.insn_valid !== 1'b1 || bus.insn_pc !== a) begin
          bad++;
          $display("FAIL wrap_pc i=%0d got v=%b pc=%h want v=1 pc=%h", i, bus.insn_valid, bus.insn_pc, a);
        end
      end
    end
    @(negedge clk);
    lat = 3;
    #1;
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_ack !== 1'b0 || bus.insn_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre got req=%b ack=%b v=%b want req=1 ack=0 v=1",
               bus.mem_req, bus.mem_ack, bus.insn_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.insn_valid !== 1'b0 ||
        bus.insn !== 32'h0 || bus.insn_pc !== 32'h0) begin
      bad++;
      $display("FAIL midrst_vals got req=%b addr=%h v=%b insn=%h pc=%h want all 0",
               bus.mem_req, bus.mem_addr, bus.insn_valid, bus.insn, bus.insn_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL midrst_release got req=%b addr=%h want req=1 addr=0", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp = 32'h0;
    int n = 0;
    logic pv_req = 0, pv_ack = 0, pv_valid = 0, pv_ready = 0, pv_redir = 0;
    logic [31:0] pv_addr = 0, pv_pc = 0, pv_insn = 0;
    apply_reset;
    for (int c = 0; c < 800; c++) begin
      bus.insn_ready = ($urandom_range(0, 9) < 7);
      lat = $urandom_range(0, 3);
      bus.redirect = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = $urandom;
      #1;
      total++;
      if (bus.mem_addr[1:0] !== 2'b00) begin
        bad++;
        $display("FAIL rnd_align c=%0d got addr=%h want low bits 00", c, bus.mem_addr);
      end
      if (pv_req && !pv_ack) begin
        total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== pv_addr) begin
          bad++;
          $display("FAIL rnd_addr_hold c=%0d got req=%b addr=%h want req=1 addr=%h",
                   c, bus.mem_req, bus.mem_addr, pv_addr);
        end
      end
      if (pv_valid && !pv_ready && !pv_redir) begin
        total++;
        if (bus.insn_valid !== 1'b1 || bus.insn_pc !== pv_pc || bus.insn !== pv_insn) begin
          bad++;
          $display("FAIL rnd_insn_hold c=%0d got v=%b pc=%h want v=1 pc=%h",
                   c, bus.insn_valid, bus.insn_pc, pv_pc);
        end
      end
      if (bus.insn_valid && bus.insn_ready) begin
        total++;
        if (bus.insn_pc !== exp || bus.insn !== memf(exp)) begin
          bad++;
          $display("FAIL rnd_stream c=%0d got pc=%h insn=%h want pc=%h insn=%h",
                   c, bus.insn_pc, bus.insn, exp, memf(exp));
        end
        exp += 4;
        n++;
      end
      if (bus.redirect) exp = bus.redirect_pc & ~32'h3;
      pv_req = bus.mem_req;  pv_ack = bus.mem_ack;  pv_addr = bus.mem_addr;
      pv_valid = bus.insn_valid;  pv_ready = bus.insn_ready;  pv_redir = bus.redirect;
      pv_pc = bus.insn_pc;  pv_insn = bus.insn;
      @(negedge clk);
    end
    bus.redirect = 1'b0;
    total++;
    if (n < 100) begin
      bad++;
      $display("FAIL rnd_progress got %0d deliveries want >=100", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_seq;
    test_stall;
    test_redirect_full;
    test_drain;
    test_double_redirect;
    test_wrap_rst;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
